int_controller: RTL and testbench

//  Interrupt controller: receiving end of the peripheral int_req/int_ack handshake. Video drives int_req[0]=VBlank
//  and int_req[1]=LCDC; timer, serial and joypad drive bits 2-4. Holds IF (0xFF0F) and IE (0xFFFF) behind the
//  MMU-style register bus, resolves priority, presents one vector to the CPU, and on CPU acknowledge returns a
//  one-cycle int_ack to the serviced source. IME lives in the CPU; this block only qualifies by IE.

---
 rtl/int_controller.sv | 160 ++++++++++++++++
 tb/tb_int_controller.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/int_controller.sv
// int_controller
//   Receiving end of the peripheral int_req/int_ack handshake. Holds the
//   interrupt flag (IF) and interrupt enable (IE) registers behind the
//   MMU register bus. It resolves priority among the enabled pending
//   sources and presents a single vector to the CPU. When the CPU takes
//   the dispatch, it returns a one-cycle acknowledge to the serviced
//   peripheral. The master enable (IME) lives in the CPU, so this block
//   only qualifies requests by IE.
//
//   The read-data port is named rd_data because "do" is a reserved
//   SystemVerilog keyword.
module int_controller #(
   parameter int          NUM_SRC     = 5,
   parameter logic [15:0] IF_ADDR     = 16'hFF0F,
   parameter logic [15:0] IE_ADDR     = 16'hFFFF,
   parameter logic [7:0]  VECTOR_BASE = 8'h40
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               mem_enable,
   input  logic               rd_n,
   input  logic               wr_n,
   input  logic [15:0]        A,
   input  logic [7:0]         di,
   output logic [7:0]         rd_data,
   input  logic [NUM_SRC-1:0] int_req,
   output logic [NUM_SRC-1:0] int_ack,
   output logic               cpu_int,
   output logic [7:0]         cpu_vector,
   input  logic               cpu_int_ack
);

   localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PEND = 2'd1,
      ACK  = 2'd2
   } state_t;

   state_t             state;
   logic [NUM_SRC-1:0] if_reg;
   logic [NUM_SRC-1:0] ie_reg;
   logic [NUM_SRC-1:0] req_prev;

   logic               wr_en;
   logic               rd_en;
   logic               if_wr;
   logic               ie_wr;
   logic [NUM_SRC-1:0] evt;
   logic [NUM_SRC-1:0] pend;
   logic [IDX_W-1:0]   sel;
   logic [NUM_SRC-1:0] sel_onehot;
   logic               ack_take;
   logic [NUM_SRC-1:0] clr;
   logic [NUM_SRC-1:0] if_base;
   logic [NUM_SRC-1:0] if_next;
   logic [7:0]         rd_mux;

   // Bits 7:5 of the written data are not stored anywhere.
   logic               unused_di;
   assign unused_di = ^di[7:NUM_SRC];

   assign wr_en = mem_enable & ~wr_n;
   assign rd_en = mem_enable & ~rd_n;
   assign if_wr = wr_en && (A == IF_ADDR);
   assign ie_wr = wr_en && (A == IE_ADDR);

   // A request sets IF only on its rising edge, so a held level sets it once.
   assign evt  = int_req & ~req_prev;
   assign pend = ie_reg & if_reg;

   // Priority encoder: the lowest set index of pend wins.
   // NOTE: always_comb gives every output a default first, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      sel = '0;
      for (int i = NUM_SRC - 1; i >= 0; i--) begin
         if (pend[i]) sel = IDX_W'(i);
      end
   end

   assign sel_onehot = NUM_SRC'(1) << sel;

   // The CPU acknowledge is honoured only in PEND while something is still pending.
   assign ack_take = (state == PEND) && (pend != '0) && cpu_int_ack;
   assign clr      = ack_take ? sel_onehot : '0;

   // Next IF: a new event beats the dispatch clear, and the clear beats a CPU write.
   assign if_base = if_wr ? di[NUM_SRC-1:0] : if_reg;
   assign if_next = (if_base & ~clr) | evt;

   // Read mux of the pre-update register values; unimplemented bits read as 1.
   always_comb begin
      rd_mux = 8'hFF;
      if (A == IF_ADDR) begin
         rd_mux = {{(8 - NUM_SRC){1'b1}}, if_reg};
      end else if (A == IE_ADDR) begin
         rd_mux = {{(8 - NUM_SRC){1'b1}}, ie_reg};
      end
   end

   // Flag/enable registers and the request edge detector.
   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock) begin
      if (reset) begin
         if_reg   <= '0;
         ie_reg   <= '0;
         req_prev <= '0;
      end else begin
         req_prev <= int_req;
         if_reg   <= if_next;
         if (ie_wr) ie_reg <= di[NUM_SRC-1:0];
      end
   end

   // Registered read data: one-cycle latency; holds its value between reads.
   always_ff @(posedge clock) begin
      if (reset) begin
         rd_data <= 8'hFF;
      end else if (rd_en) begin
         rd_data <= rd_mux;
      end
   end

   // Dispatch FSM. int_ack is loaded with the serviced source as the FSM enters ACK,
   // so it is high for exactly the ACK cycle.
   always_ff @(posedge clock) begin
      if (reset) begin
         state   <= IDLE;
         int_ack <= '0;
      end else begin
         int_ack <= '0;
         case (state)
            IDLE: begin
               if (pend != '0) state <= PEND;
            end
            PEND: begin
               if (pend == '0) begin
                  state <= IDLE;
               end else if (cpu_int_ack) begin
                  int_ack <= sel_onehot;
                  state   <= ACK;
               end
            end
            ACK: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // CPU-facing outputs follow the live pending set while in PEND, so a
   // higher-priority source can take over the vector until the CPU acknowledges.
   assign cpu_int    = (state == PEND) && (pend != '0);
   assign cpu_vector = cpu_int ? (VECTOR_BASE + (8'(sel) << 3)) : 8'h00;

endmodule

// File: tb/tb_int_controller.sv
// tb_int_controller
//   Directed, table-driven bench for int_controller. Each table row gives the
//   inputs held across one rising edge and the outputs expected after it.
//   Hand-written sequences cover reset in the middle of a handshake.
module tb_int_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        mem_enable;
   logic        rd_n;
   logic        wr_n;
   logic [15:0] addr;
   logic [7:0]  di;
   logic [7:0]  rd_data;
   logic [4:0]  int_req;
   logic [4:0]  int_ack;
   logic        cpu_int;
   logic [7:0]  cpu_vector;
   logic        cpu_int_ack;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   int_controller dut (
      .clock       (clock),
      .reset       (reset),
      .mem_enable  (mem_enable),
      .rd_n        (rd_n),
      .wr_n        (wr_n),
      .A           (addr),
      .di          (di),
      .rd_data     (rd_data),
      .int_req     (int_req),
      .int_ack     (int_ack),
      .cpu_int     (cpu_int),
      .cpu_vector  (cpu_vector),
      .cpu_int_ack (cpu_int_ack)
   );

   typedef struct {
      logic        rst;
      logic        wr;
      logic        rd;
      logic [15:0] a;
      logic [7:0]  wd;
      logic [4:0]  req;
      logic        cack;
      logic        exp_int;
      logic [7:0]  exp_vec;
      logic [4:0]  exp_ack;
      logic [7:0]  exp_rd;
   } vec_t;

   vec_t tbl[$];

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %02h expected %02h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic drive(input logic rst, input logic wr, input logic rd, input logic [15:0] a,
                        input logic [7:0] wd, input logic [4:0] req, input logic cack);
      reset       = rst;
      mem_enable  = wr | rd;
      wr_n        = ~wr;
      rd_n        = ~rd;
      addr        = a;
      di          = wd;
      int_req     = req;
      cpu_int_ack = cack;
   endtask

   // Advance one rising edge and settle just after it.
   task automatic tick;
      @(posedge clock);
      #1;
   endtask

   task automatic check_outs(input string tag, input logic e_int, input logic [7:0] e_vec,
                             input logic [4:0] e_ack);
      check({tag, ".cpu_int"}, {7'd0, cpu_int}, {7'd0, e_int});
      check({tag, ".cpu_vector"}, cpu_vector, e_vec);
      check({tag, ".int_ack"}, {3'd0, int_ack}, {3'd0, e_ack});
   endtask

   initial begin
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 5'b00000, 1'b0);

      //                rst  wr   rd   addr      wd     req       ck   int  vec    ack       rd
      // Reset state and post-reset reads
      tbl.push_back(vec_t'{1'b1,1'b0,1'b1,16'hFF0F,8'h00,5'b00000,1'b0,1'b0,8'h00,5'b00000,8'hFF});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b1,16'hFF0F,8'h00,5'b00000,1'b0,1'b0,8'h00,5'b00000,8'hE0});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b1,16'hFFFF,8'h00,5'b00000,1'b0,1'b0,8'h00,5'b00000,8'hE0});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b1,16'h1234,8'h00,5'b00000,1'b0,1'b0,8'h00,5'b00000,8'hFF});
      // VBlank: IE=01, raise and hold req[0], dispatch and ack
      tbl.push_back(vec_t'{1'b0,1'b1,1'b0,16'hFFFF,8'h01,5'b00000,1'b0,1'b0,8'h00,5'b00000,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b0,16'h0000,8'h00,5'b00001,1'b0,1'b0,8'h00,5'b00000,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b1,16'hFF0F,8'h00,5'b00001,1'b0,1'b1,8'h40,5'b00000,8'hE1});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b0,16'h0000,8'h00,5'b00001,1'b1,1'b0,8'h00,5'b00001,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b1,16'hFF0F,8'h00,5'b00001,1'b0,1'b0,8'h00,5'b00000,8'hE0});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b1,16'hFF0F,8'h00,5'b00001,1'b0,1'b0,8'h00,5'b00000,8'hE0});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b0,16'h0000,8'h00,5'b00000,1'b0,1'b0,8'h00,5'b00000,8'h00});
      // Priority: timer then LCDC before ack; LCDC serviced, timer re-dispatches
      tbl.push_back(vec_t'{1'b0,1'b1,1'b0,16'hFFFF,8'h1F,5'b00000,1'b0,1'b0,8'h00,5'b00000,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b0,16'h0000,8'h00,5'b00100,1'b0,1'b0,8'h00,5'b00000,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b0,16'h0000,8'h00,5'b00100,1'b0,1'b1,8'h50,5'b00000,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b0,16'h0000,8'h00,5'b00110,1'b0,1'b1,8'h48,5'b00000,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b0,16'h0000,8'h00,5'b00110,1'b1,1'b0,8'h00,5'b00010,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b1,16'hFF0F,8'h00,5'b00110,1'b0,1'b0,8'h00,5'b00000,8'hE4});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b0,16'h0000,8'h00,5'b00110,1'b0,1'b1,8'h50,5'b00000,8'h00});
      // Software clears IF while pending: cpu_int drops, FSM returns to IDLE
      tbl.push_back(vec_t'{1'b0,1'b1,1'b0,16'hFF0F,8'h00,5'b00110,1'b0,1'b0,8'h00,5'b00000,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b0,16'h0000,8'h00,5'b00000,1'b0,1'b0,8'h00,5'b00000,8'h00});
      // Disabled source latches in IF; enabling it later dispatches
      tbl.push_back(vec_t'{1'b0,1'b1,1'b0,16'hFFFF,8'h00,5'b00000,1'b0,1'b0,8'h00,5'b00000,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b0,16'h0000,8'h00,5'b01000,1'b0,1'b0,8'h00,5'b00000,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b1,16'hFF0F,8'h00,5'b01000,1'b0,1'b0,8'h00,5'b00000,8'hE8});
      tbl.push_back(vec_t'{1'b0,1'b1,1'b0,16'hFFFF,8'h08,5'b01000,1'b0,1'b0,8'h00,5'b00000,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b0,16'h0000,8'h00,5'b01000,1'b0,1'b1,8'h58,5'b00000,8'h00});
      // Same-cycle IF write of 00 and joypad edge: set wins
      tbl.push_back(vec_t'{1'b0,1'b1,1'b0,16'hFF0F,8'h00,5'b11000,1'b0,1'b0,8'h00,5'b00000,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b1,16'hFF0F,8'h00,5'b11000,1'b0,1'b0,8'h00,5'b00000,8'hF0});
      // cpu_int_ack in IDLE and in ACK is ignored; upper IE bits dropped on write
      tbl.push_back(vec_t'{1'b0,1'b1,1'b0,16'hFFFF,8'hF0,5'b11000,1'b0,1'b0,8'h00,5'b00000,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b1,16'hFFFF,8'h00,5'b11000,1'b1,1'b1,8'h60,5'b00000,8'hF0});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b1,16'hFF0F,8'h00,5'b11000,1'b0,1'b1,8'h60,5'b00000,8'hF0});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b0,16'h0000,8'h00,5'b11000,1'b1,1'b0,8'h00,5'b10000,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b0,16'h0000,8'h00,5'b11000,1'b1,1'b0,8'h00,5'b00000,8'h00});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b1,16'hFF0F,8'h00,5'b11000,1'b0,1'b0,8'h00,5'b00000,8'hE0});
      tbl.push_back(vec_t'{1'b0,1'b0,1'b0,16'h0000,8'h00,5'b00000,1'b0,1'b0,8'h00,5'b00000,8'h00});

      for (int i = 0; i < tbl.size(); i++) begin
         drive(tbl[i].rst, tbl[i].wr, tbl[i].rd, tbl[i].a, tbl[i].wd, tbl[i].req, tbl[i].cack);
         tick();
         check_outs($sformatf("row%0d", i), tbl[i].exp_int, tbl[i].exp_vec, tbl[i].exp_ack);
         if (tbl[i].rd) check($sformatf("row%0d.do", i), rd_data, tbl[i].exp_rd);
      end

      // Reset while in PEND with a same-cycle CPU acknowledge: no int_ack, outputs cleared.
      drive(1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h01, 5'b00000, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 5'b00001, 1'b0); tick();
      tick();
      check_outs("pend_before_rst", 1'b1, 8'h40, 5'b00000);
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 5'b00001, 1'b1); tick();
      check_outs("rst_in_pend", 1'b0, 8'h00, 5'b00000);
      check("rst_in_pend.do", rd_data, 8'hFF);
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 5'b00001, 1'b0); tick();
      check_outs("rst_held", 1'b0, 8'h00, 5'b00000);

      // Request held high through reset release counts as one edge; IE was cleared.
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 5'b00001, 1'b0); tick();
      check_outs("rst_release", 1'b0, 8'h00, 5'b00000);
      drive(1'b0, 1'b0, 1'b1, 16'hFF0F, 8'h00, 5'b00001, 1'b0); tick();
      check("rst_release.if", rd_data, 8'hE1);
      drive(1'b0, 1'b0, 1'b1, 16'hFFFF, 8'h00, 5'b00001, 1'b0); tick();
      check("rst_release.ie", rd_data, 8'hE0);

      // Reset during the ACK cycle kills the handshake.
      drive(1'b0, 1'b1, 1'b0, 16'hFFFF, 8'h01, 5'b00001, 1'b0); tick();
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 5'b00001, 1'b0); tick();
      check_outs("pend_again", 1'b1, 8'h40, 5'b00000);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 5'b00001, 1'b1); tick();
      check_outs("ack_cycle", 1'b0, 8'h00, 5'b00001);
      drive(1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 5'b00001, 1'b0); tick();
      check_outs("rst_in_ack", 1'b0, 8'h00, 5'b00000);
      drive(1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 5'b00000, 1'b0); tick();
      check_outs("after_rst_ack", 1'b0, 8'h00, 5'b00000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
